// File: rtl/ct_mat_cfg_pkg.sv
// ---------------------------------------------------------------------------
// Package: ct_mat_cfg_pkg
// Purpose: Shared types and helpers for the matrix-config checkpoint unit.
//   - one-hot optype codes carried on idu_mat_rf_pipe8_cfg_meta ({ALL,N,M,K})
//   - cfg_snap_t: full post-op size snapshot held per uncommitted cfg op
//   - pack_xmsize: packs sizes into the 64-bit {zero, K, N, M} layout used by
//     both the GPR writeback data and the committed xmsize CSR image
// ---------------------------------------------------------------------------
package ct_mat_cfg_pkg;

    localparam int CFG_IID_W    = 7;
    localparam int CFG_SIZE_K_W = 16;
    localparam int CFG_SIZE_M_W = 8;
    localparam int CFG_SIZE_N_W = 8;

    // One-hot optype codes, bit order {ALL, N, M, K}
    localparam logic [3:0] OP_K   = 4'b0001;
    localparam logic [3:0] OP_M   = 4'b0010;
    localparam logic [3:0] OP_N   = 4'b0100;
    localparam logic [3:0] OP_ALL = 4'b1000;

    typedef struct packed {
        logic [CFG_IID_W-1:0]    iid;
        logic [CFG_SIZE_K_W-1:0] k;
        logic [CFG_SIZE_M_W-1:0] m;
        logic [CFG_SIZE_N_W-1:0] n;
    } cfg_snap_t;

    // M occupies the low bits, N sits above M, K above N, rest zero.
    function automatic logic [63:0] pack_xmsize(
        input logic [CFG_SIZE_K_W-1:0] k,
        input logic [CFG_SIZE_M_W-1:0] m,
        input logic [CFG_SIZE_N_W-1:0] n
    );
        logic [63:0] r;
        r = '0;
        r[0 +: CFG_SIZE_M_W]                             = m;
        r[CFG_SIZE_M_W +: CFG_SIZE_N_W]                  = n;
        r[CFG_SIZE_M_W + CFG_SIZE_N_W +: CFG_SIZE_K_W]   = k;
        return r;
    endfunction

endpackage

// File: rtl/ct_mat_cfg_ckpt_unit_if.sv
// ---------------------------------------------------------------------------
// Interface: ct_mat_cfg_ckpt_unit_if
// Purpose: Bundles every non-clock/reset signal of ct_mat_cfg_ckpt_unit.
//   slave  modport : the cfg unit (consumes issue/retire/flush, drives results)
//   master modport : the surrounding pipeline (IDU/RTU side)
// Signals:
//   rtu_yy_xx_flush               pipeline flush
//   idu_mat_rf_cfg_sel            RF issues a cfg op (valid)
//   idu_mat_rf_pipe8_*            iid / one-hot optype / dst info / rs1 value
//   rtu_mat_cfg_retire_vld/_iid   retire of the oldest cfg op
//   mat_cfg_idu_full              back-pressure to RF for the next cycle
//   x_sizeK/M/N                   speculative sizes
//   mat_cfg_cbus_ex1_pipe8_*      complete bus
//   mat_cfg_ex1_wb_preg_*         GPR writeback
//   mat_cfg_ex1_sat               EX1 value was clamped
//   mat_cfg_sync_xmsize_csr       committed {zero, K, N, M}
// ---------------------------------------------------------------------------
interface ct_mat_cfg_ckpt_unit_if #(
    parameter int IID_W    = 7,
    parameter int PREG_W   = 7,
    parameter int SIZE_K_W = 16,
    parameter int SIZE_M_W = 8,
    parameter int SIZE_N_W = 8
);
    logic                rtu_yy_xx_flush;
    logic                idu_mat_rf_cfg_sel;
    logic [IID_W-1:0]    idu_mat_rf_pipe8_iid;
    logic [3:0]          idu_mat_rf_pipe8_cfg_meta;
    logic                idu_mat_rf_pipe8_cfg_dst_vld;
    logic [PREG_W-1:0]   idu_mat_rf_pipe8_cfg_dst_preg;
    logic [63:0]         idu_mat_rf_pipe8_cfg_src0;
    logic                rtu_mat_cfg_retire_vld;
    logic [IID_W-1:0]    rtu_mat_cfg_retire_iid;

    logic                mat_cfg_idu_full;
    logic [SIZE_K_W-1:0] x_sizeK;
    logic [SIZE_M_W-1:0] x_sizeM;
    logic [SIZE_N_W-1:0] x_sizeN;
    logic                mat_cfg_cbus_ex1_pipe8_sel;
    logic [IID_W-1:0]    mat_cfg_cbus_ex1_pipe8_iid;
    logic                mat_cfg_ex1_wb_preg_vld;
    logic [PREG_W-1:0]   mat_cfg_ex1_wb_preg;
    logic [63:0]         mat_cfg_ex1_wb_preg_data;
    logic                mat_cfg_ex1_sat;
    logic [63:0]         mat_cfg_sync_xmsize_csr;

    modport slave (
        input  rtu_yy_xx_flush, idu_mat_rf_cfg_sel, idu_mat_rf_pipe8_iid,
               idu_mat_rf_pipe8_cfg_meta, idu_mat_rf_pipe8_cfg_dst_vld,
               idu_mat_rf_pipe8_cfg_dst_preg, idu_mat_rf_pipe8_cfg_src0,
               rtu_mat_cfg_retire_vld, rtu_mat_cfg_retire_iid,
        output mat_cfg_idu_full, x_sizeK, x_sizeM, x_sizeN,
               mat_cfg_cbus_ex1_pipe8_sel, mat_cfg_cbus_ex1_pipe8_iid,
               mat_cfg_ex1_wb_preg_vld, mat_cfg_ex1_wb_preg,
               mat_cfg_ex1_wb_preg_data, mat_cfg_ex1_sat,
               mat_cfg_sync_xmsize_csr
    );

    modport master (
        output rtu_yy_xx_flush, idu_mat_rf_cfg_sel, idu_mat_rf_pipe8_iid,
               idu_mat_rf_pipe8_cfg_meta, idu_mat_rf_pipe8_cfg_dst_vld,
               idu_mat_rf_pipe8_cfg_dst_preg, idu_mat_rf_pipe8_cfg_src0,
               rtu_mat_cfg_retire_vld, rtu_mat_cfg_retire_iid,
        input  mat_cfg_idu_full, x_sizeK, x_sizeM, x_sizeN,
               mat_cfg_cbus_ex1_pipe8_sel, mat_cfg_cbus_ex1_pipe8_iid,
               mat_cfg_ex1_wb_preg_vld, mat_cfg_ex1_wb_preg,
               mat_cfg_ex1_wb_preg_data, mat_cfg_ex1_sat,
               mat_cfg_sync_xmsize_csr
    );

endinterface

// File: rtl/ct_mat_cfg_ckpt_fifo.sv
// ---------------------------------------------------------------------------
// Module: ct_mat_cfg_ckpt_fifo
// Purpose: In-order FIFO of uncommitted cfg snapshots (cfg_snap_t).
//   Push appends the EX1 post-op snapshot, pop drops the head on retire,
//   clear empties the FIFO on flush (clear dominates push and pop).
// Ports:
//   ctrl_clk, cpurst_b   clock, async active-low reset
//   i_push, i_push_data  append snapshot
//   i_pop                drop head
//   i_clear              empty the FIFO
//   o_head               current head snapshot (valid when !o_empty)
//   o_count              occupancy, 0..DEPTH
//   o_full, o_empty      occupancy flags
// ---------------------------------------------------------------------------
module ct_mat_cfg_ckpt_fifo
    import ct_mat_cfg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       ctrl_clk,
    input  logic                       cpurst_b,
    input  logic                       i_push,
    input  cfg_snap_t                  i_push_data,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output cfg_snap_t                  o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cfg_snap_t           r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_push_ok;
    logic                w_pop_ok;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rptr];

    // A push into a full FIFO is only accepted when a pop frees the head
    // slot in the same cycle.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge ctrl_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
        end
    end

endmodule

// File: rtl/ct_mat_cfg_ckpt_unit.sv
// ---------------------------------------------------------------------------
// Module: ct_mat_cfg_ckpt_unit
// Purpose: Matrix-config execute unit on pipe8 with checkpointing.
//   RF->EX1 is one register stage. EX1 decodes the one-hot optype, builds the
//   new speculative K/M/N sizes, completes on the cbus, writes back the GPR
//   and pushes the post-op snapshot into an in-order FIFO. Retire pops the
//   head into the committed sizes; flush drops EX1, empties the FIFO and
//   rolls speculative sizes back to the (post-retire) committed sizes.
// Configuration macro:
//   MAT_CFG_SAT_EN  defined   -> written fields clamp to MAX_*, sat reports it
//                   undefined -> fields are truncated to width, sat is 0
// Ports:
//   ctrl_clk   clock
//   cpurst_b   reset, asynchronous, active-low
//   bus        ct_mat_cfg_ckpt_unit_if.slave (issue, retire, flush, results)
// Handshake: idu_mat_rf_cfg_sel is a valid qualified by the previous-cycle
//   view of mat_cfg_idu_full; full is raised one op early (count==DEPTH-1 with
//   an op in EX1) because the issued op only pushes two edges later.
// ---------------------------------------------------------------------------
module ct_mat_cfg_ckpt_unit
    import ct_mat_cfg_pkg::*;
#(
    parameter int SIZE_K_W = 16,
    parameter int SIZE_M_W = 8,
    parameter int SIZE_N_W = 8,
    parameter int MAX_K    = 512,
    parameter int MAX_M    = 16,
    parameter int MAX_N    = 16,
    parameter int IID_W    = 7,
    parameter int PREG_W   = 7,
    parameter int DEPTH    = 4
) (
    input  logic                    ctrl_clk,
    input  logic                    cpurst_b,
    ct_mat_cfg_ckpt_unit_if.slave   bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // ---------------- RF -> EX1 stage ----------------
    logic                r_ex1_vld;
    logic [IID_W-1:0]    r_ex1_iid;
    logic [3:0]          r_ex1_meta;
    logic                r_ex1_dst_vld;
    logic [PREG_W-1:0]   r_ex1_preg;
    logic [63:0]         r_ex1_src0;

    always_ff @(posedge ctrl_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_ex1_vld     <= 1'b0;
            r_ex1_iid     <= '0;
            r_ex1_meta    <= '0;
            r_ex1_dst_vld <= 1'b0;
            r_ex1_preg    <= '0;
            r_ex1_src0    <= '0;
        end else begin
            r_ex1_vld <= bus.idu_mat_rf_cfg_sel & ~bus.rtu_yy_xx_flush;
            if (bus.idu_mat_rf_cfg_sel) begin
                r_ex1_iid     <= bus.idu_mat_rf_pipe8_iid;
                r_ex1_meta    <= bus.idu_mat_rf_pipe8_cfg_meta;
                r_ex1_dst_vld <= bus.idu_mat_rf_pipe8_cfg_dst_vld;
                r_ex1_preg    <= bus.idu_mat_rf_pipe8_cfg_dst_preg;
                r_ex1_src0    <= bus.idu_mat_rf_pipe8_cfg_src0;
            end
        end
    end

    // ---------------- size state ----------------
    logic [SIZE_K_W-1:0] r_spec_k, r_comm_k;
    logic [SIZE_M_W-1:0] r_spec_m, r_comm_m;
    logic [SIZE_N_W-1:0] r_spec_n, r_comm_n;

    // ---------------- EX1 decode ----------------
    logic                w_k_wr, w_m_wr, w_n_wr;
    logic [SIZE_K_W-1:0] w_k_fld, w_k_val, w_new_k;
    logic [SIZE_M_W-1:0] w_m_fld, w_m_val, w_new_m;
    logic [SIZE_N_W-1:0] w_n_fld, w_n_val, w_new_n;
    logic                w_sat_raw;
    logic                w_ex1_go;

    // Single-field ops take their value from the low bits of rs1; ALL takes
    // M, N, K from consecutive fields in the same layout as the xmsize CSR.
    // Non one-hot meta selects nothing, so the op completes with sizes intact.
    always_comb begin
        w_k_wr  = 1'b0;
        w_m_wr  = 1'b0;
        w_n_wr  = 1'b0;
        w_k_fld = r_ex1_src0[0 +: SIZE_K_W];
        w_m_fld = r_ex1_src0[0 +: SIZE_M_W];
        w_n_fld = r_ex1_src0[0 +: SIZE_N_W];
        case (r_ex1_meta)
            OP_K:    w_k_wr = 1'b1;
            OP_M:    w_m_wr = 1'b1;
            OP_N:    w_n_wr = 1'b1;
            OP_ALL: begin
                w_k_wr  = 1'b1;
                w_m_wr  = 1'b1;
                w_n_wr  = 1'b1;
                w_n_fld = r_ex1_src0[SIZE_M_W +: SIZE_N_W];
                w_k_fld = r_ex1_src0[SIZE_M_W + SIZE_N_W +: SIZE_K_W];
            end
            default: ;
        endcase
    end

`ifdef MAT_CFG_SAT_EN
    localparam logic [SIZE_K_W-1:0] K_LIM = SIZE_K_W'(MAX_K);
    localparam logic [SIZE_M_W-1:0] M_LIM = SIZE_M_W'(MAX_M);
    localparam logic [SIZE_N_W-1:0] N_LIM = SIZE_N_W'(MAX_N);

    logic w_k_ovf, w_m_ovf, w_n_ovf;

    // Only fields the op actually writes can saturate.
    assign w_k_ovf   = w_k_wr & (w_k_fld > K_LIM);
    assign w_m_ovf   = w_m_wr & (w_m_fld > M_LIM);
    assign w_n_ovf   = w_n_wr & (w_n_fld > N_LIM);
    assign w_k_val   = w_k_ovf ? K_LIM : w_k_fld;
    assign w_m_val   = w_m_ovf ? M_LIM : w_m_fld;
    assign w_n_val   = w_n_ovf ? N_LIM : w_n_fld;
    assign w_sat_raw = w_k_ovf | w_m_ovf | w_n_ovf;
`else
    assign w_k_val   = w_k_fld;
    assign w_m_val   = w_m_fld;
    assign w_n_val   = w_n_fld;
    assign w_sat_raw = 1'b0;
`endif

    assign w_new_k = w_k_wr ? w_k_val : r_spec_k;
    assign w_new_m = w_m_wr ? w_m_val : r_spec_m;
    assign w_new_n = w_n_wr ? w_n_val : r_spec_n;

    // A flush in the EX1 cycle kills the op: no complete, no wb, no push.
    assign w_ex1_go = r_ex1_vld & ~bus.rtu_yy_xx_flush;

    // ---------------- checkpoint FIFO ----------------
    cfg_snap_t           w_push_snap;
    cfg_snap_t           w_head;
    logic [CNT_W-1:0]    w_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_retire;

    assign w_push_snap.iid = r_ex1_iid;
    assign w_push_snap.k   = w_new_k;
    assign w_push_snap.m   = w_new_m;
    assign w_push_snap.n   = w_new_n;

    assign w_retire = bus.rtu_mat_cfg_retire_vld & ~w_fifo_empty;

    ct_mat_cfg_ckpt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .ctrl_clk    (ctrl_clk),
        .cpurst_b    (cpurst_b),
        .i_push      (w_ex1_go),
        .i_push_data (w_push_snap),
        .i_pop       (bus.rtu_mat_cfg_retire_vld),
        .i_clear     (bus.rtu_yy_xx_flush),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // ---------------- committed / speculative update ----------------
    logic [SIZE_K_W-1:0] w_comm_k_nxt;
    logic [SIZE_M_W-1:0] w_comm_m_nxt;
    logic [SIZE_N_W-1:0] w_comm_n_nxt;

    assign w_comm_k_nxt = w_retire ? w_head.k : r_comm_k;
    assign w_comm_m_nxt = w_retire ? w_head.m : r_comm_m;
    assign w_comm_n_nxt = w_retire ? w_head.n : r_comm_n;

    // Flush restores from the post-retire committed view, so a retire in the
    // flush cycle is not lost.
    always_ff @(posedge ctrl_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_comm_k <= '0;
            r_comm_m <= '0;
            r_comm_n <= '0;
            r_spec_k <= '0;
            r_spec_m <= '0;
            r_spec_n <= '0;
        end else begin
            r_comm_k <= w_comm_k_nxt;
            r_comm_m <= w_comm_m_nxt;
            r_comm_n <= w_comm_n_nxt;
            if (bus.rtu_yy_xx_flush) begin
                r_spec_k <= w_comm_k_nxt;
                r_spec_m <= w_comm_m_nxt;
                r_spec_n <= w_comm_n_nxt;
            end else if (w_ex1_go) begin
                r_spec_k <= w_new_k;
                r_spec_m <= w_new_m;
                r_spec_n <= w_new_n;
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.mat_cfg_idu_full = w_fifo_full |
                                  ((w_count == CNT_W'(DEPTH - 1)) & r_ex1_vld);

    assign bus.x_sizeK = r_spec_k;
    assign bus.x_sizeM = r_spec_m;
    assign bus.x_sizeN = r_spec_n;

    assign bus.mat_cfg_cbus_ex1_pipe8_sel = w_ex1_go;
    assign bus.mat_cfg_cbus_ex1_pipe8_iid = r_ex1_iid;
    assign bus.mat_cfg_ex1_wb_preg_vld    = w_ex1_go & r_ex1_dst_vld;
    assign bus.mat_cfg_ex1_wb_preg        = r_ex1_preg;
    assign bus.mat_cfg_ex1_wb_preg_data   = w_ex1_go ? pack_xmsize(w_new_k, w_new_m, w_new_n) : 64'd0;
    assign bus.mat_cfg_ex1_sat            = w_ex1_go & w_sat_raw;
    assign bus.mat_cfg_sync_xmsize_csr    = pack_xmsize(r_comm_k, r_comm_m, r_comm_n);

    // ---------------- protocol checks ----------------
    a_retire_head: assert property (@(posedge ctrl_clk) disable iff (!cpurst_b)
        bus.rtu_mat_cfg_retire_vld |-> (!w_fifo_empty && (w_head.iid == bus.rtu_mat_cfg_retire_iid)));

    a_issue_not_full: assert property (@(posedge ctrl_clk) disable iff (!cpurst_b)
        bus.idu_mat_rf_cfg_sel |-> !w_fifo_full);

endmodule

// File: tb/tb_ct_mat_cfg_ckpt_unit.sv
// ---------------------------------------------------------------------------
// Testbench: tb_ct_mat_cfg_ckpt_unit
// Directed steps followed by a randomized phase, all checked against a
// transaction-level model: speculative/committed sizes as integers and a
// queue of pending snapshots {iid,K,M,N}.
// ---------------------------------------------------------------------------
module tb_ct_mat_cfg_ckpt_unit;
  import ct_mat_cfg_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ct_mat_cfg_ckpt_unit_if #(
    .IID_W(7), .PREG_W(7), .SIZE_K_W(16), .SIZE_M_W(8), .SIZE_N_W(8)
  ) bus ();

  ct_mat_cfg_ckpt_unit #(
    .SIZE_K_W(16), .SIZE_M_W(8), .SIZE_N_W(8),
    .MAX_K(512), .MAX_M(16), .MAX_N(16),
    .IID_W(7), .PREG_W(7), .DEPTH(DEPTH)
  ) dut (
    .ctrl_clk (clk),
    .cpurst_b (rst_b),
    .bus      (bus)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;

  logic [38:0] exp_q[$];   // {iid[6:0], K[15:0], M[7:0], N[7:0]}
  logic        m_v;
  logic [6:0]  m_iid;
  logic [3:0]  m_meta;
  logic        m_dst;
  logic [6:0]  m_preg;
  logic [63:0] m_src;
  int          m_sk, m_sm, m_sn;
  int          m_ck, m_cm, m_cn;
  logic [6:0]  next_iid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] xm(input int k, input int m, input int n);
    return (64'(k) << 16) | (64'(n) << 8) | 64'(m);
  endfunction

  function automatic bit model_full();
    return (exp_q.size() == DEPTH) || (exp_q.size() == DEPTH - 1 && m_v);
  endfunction

  // Result of the op currently held in EX1, from the architectural rules.
  task automatic model_apply(output int nk, output int nm, output int nn, output bit sat);
    nk = m_sk; nm = m_sm; nn = m_sn; sat = 1'b0;
    case (m_meta)
      4'b0001: nk = int'(m_src & 64'hFFFF);
      4'b0010: nm = int'(m_src & 64'hFF);
      4'b0100: nn = int'(m_src & 64'hFF);
      4'b1000: begin
        nm = int'(m_src & 64'hFF);
        nn = int'((m_src >> 8) & 64'hFF);
        nk = int'((m_src >> 16) & 64'hFFFF);
      end
      default: ;
    endcase
`ifdef MAT_CFG_SAT_EN
    if (nk > 512) begin nk = 512; sat = 1'b1; end
    if (nm > 16)  begin nm = 16;  sat = 1'b1; end
    if (nn > 16)  begin nn = 16;  sat = 1'b1; end
`endif
  endtask

  task automatic check_outputs();
    int nk, nm, nn;
    bit sat;
    bit go;
    go = m_v && !bus.rtu_yy_xx_flush;
    model_apply(nk, nm, nn, sat);
    check("cbus_sel", 64'(bus.mat_cfg_cbus_ex1_pipe8_sel), 64'(go));
    if (go) begin
      check("cbus_iid", 64'(bus.mat_cfg_cbus_ex1_pipe8_iid), 64'(m_iid));
      check("wb_data", bus.mat_cfg_ex1_wb_preg_data, xm(nk, nm, nn));
    end
    check("wb_vld", 64'(bus.mat_cfg_ex1_wb_preg_vld), 64'(go && m_dst));
    if (go && m_dst) check("wb_preg", 64'(bus.mat_cfg_ex1_wb_preg), 64'(m_preg));
    check("sat", 64'(bus.mat_cfg_ex1_sat), 64'(go && sat));
    check("full", 64'(bus.mat_cfg_idu_full), 64'(model_full()));
    check("sizeK", 64'(bus.x_sizeK), 64'(m_sk));
    check("sizeM", 64'(bus.x_sizeM), 64'(m_sm));
    check("sizeN", 64'(bus.x_sizeN), 64'(m_sn));
    check("xmsize", bus.mat_cfg_sync_xmsize_csr, xm(m_ck, m_cm, m_cn));
  endtask

  // Model state advance at an active edge, using inputs held this cycle.
  task automatic model_edge();
    int nk, nm, nn;
    bit sat;
    logic [38:0] s;
    model_apply(nk, nm, nn, sat);
    if (bus.rtu_mat_cfg_retire_vld) begin
      s = exp_q.pop_front();
      m_ck = int'(s[31:16]); m_cm = int'(s[15:8]); m_cn = int'(s[7:0]);
    end
    if (bus.rtu_yy_xx_flush) begin
      exp_q.delete();
      m_sk = m_ck; m_sm = m_cm; m_sn = m_cn;
    end else if (m_v) begin
      m_sk = nk; m_sm = nm; m_sn = nn;
      exp_q.push_back({m_iid, 16'(nk), 8'(nm), 8'(nn)});
    end
    m_v = bus.idu_mat_rf_cfg_sel && !bus.rtu_yy_xx_flush;
    if (bus.idu_mat_rf_cfg_sel) begin
      m_iid  = bus.idu_mat_rf_pipe8_iid;
      m_meta = bus.idu_mat_rf_pipe8_cfg_meta;
      m_dst  = bus.idu_mat_rf_pipe8_cfg_dst_vld;
      m_preg = bus.idu_mat_rf_pipe8_cfg_dst_preg;
      m_src  = bus.idu_mat_rf_pipe8_cfg_src0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.idu_mat_rf_cfg_sel     = 1'b0;
    bus.rtu_mat_cfg_retire_vld = 1'b0;
    bus.rtu_yy_xx_flush        = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    idle_inputs();
  endtask

  task automatic issue(input logic [3:0] meta, input logic [63:0] src, input logic dst);
    bus.idu_mat_rf_cfg_sel           = 1'b1;
    bus.idu_mat_rf_pipe8_iid         = next_iid;
    bus.idu_mat_rf_pipe8_cfg_meta    = meta;
    bus.idu_mat_rf_pipe8_cfg_dst_vld = dst;
    bus.idu_mat_rf_pipe8_cfg_dst_preg = 7'($urandom_range(0, 127));
    bus.idu_mat_rf_pipe8_cfg_src0    = src;
    next_iid = next_iid + 7'd1;
  endtask

  task automatic retire_head();
    bus.rtu_mat_cfg_retire_vld = 1'b1;
    bus.rtu_mat_cfg_retire_iid = exp_q[0][38:32];
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH && (exp_q.size() > 0 || m_v); i++) begin
      if (exp_q.size() > 0) retire_head();
      tick();
    end
    check("drained_full", 64'(bus.mat_cfg_idu_full), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] meta;
    m_v = 1'b0; m_iid = '0; m_meta = '0; m_dst = 1'b0; m_preg = '0; m_src = '0;
    m_sk = 0; m_sm = 0; m_sn = 0; m_ck = 0; m_cm = 0; m_cn = 0;
    next_iid = 7'd1;
    bus.idu_mat_rf_pipe8_iid          = '0;
    bus.idu_mat_rf_pipe8_cfg_meta     = '0;
    bus.idu_mat_rf_pipe8_cfg_dst_vld  = 1'b0;
    bus.idu_mat_rf_pipe8_cfg_dst_preg = '0;
    bus.idu_mat_rf_pipe8_cfg_src0     = '0;
    bus.rtu_mat_cfg_retire_iid        = '0;
    idle_inputs();

    // Reset then idle: everything zero.
    rst_b = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end
    @(posedge clk);
    #1 rst_b = 1'b1;
    tick();
    tick();
    check("idle_xmsize", bus.mat_cfg_sync_xmsize_csr, 64'd0);

    // ALL op: completes one cycle after issue.
    issue(OP_ALL, 64'h0040_0808, 1'b1);
    tick();
    check("all_cbus_sel", 64'(bus.mat_cfg_cbus_ex1_pipe8_sel), 64'd1);
    check("all_wb_data", bus.mat_cfg_ex1_wb_preg_data, 64'h0040_0808);
    tick();
    check("all_sizeK", 64'(bus.x_sizeK), 64'd64);
    retire_head();
    tick();
    check("all_commit", bus.mat_cfg_sync_xmsize_csr, 64'h0040_0808);

    // M op with an over-range value.
    issue(OP_M, 64'h30, 1'b1);
    tick();
`ifdef MAT_CFG_SAT_EN
    check("m_sat", 64'(bus.mat_cfg_ex1_sat), 64'd1);
`else
    check("m_sat", 64'(bus.mat_cfg_ex1_sat), 64'd0);
`endif
    tick();
`ifdef MAT_CFG_SAT_EN
    check("m_size", 64'(bus.x_sizeM), 64'd16);
`else
    check("m_size", 64'(bus.x_sizeM), 64'h30);
`endif
    drain();

    // Fill the FIFO with K ops, issuing only while not full.
    for (int i = 0; i < 6; i++) begin
      if (!model_full()) issue(OP_K, 64'(100 + i), 1'b0);
      tick();
    end
    check("fill_full", 64'(bus.mat_cfg_idu_full), 64'd1);
    check("fill_sizeK", 64'(bus.x_sizeK), 64'd103);
    drain();

    // K=8 retired, K=32 pending, flush rolls back to 8.
    issue(OP_K, 64'd8, 1'b1);
    tick();
    tick();
    retire_head();
    issue(OP_K, 64'd32, 1'b1);
    tick();
    tick();
    bus.rtu_yy_xx_flush = 1'b1;
    tick();
    check("flush_sizeK", 64'(bus.x_sizeK), 64'd8);
    check("flush_full", 64'(bus.mat_cfg_idu_full), 64'd0);

    // Retire head and flush in the same cycle.
    issue(OP_K, 64'd40, 1'b0);
    tick();
    issue(OP_K, 64'd50, 1'b0);
    tick();
    tick();
    retire_head();
    bus.rtu_yy_xx_flush = 1'b1;
    tick();
    check("rf_sizeK", 64'(bus.x_sizeK), 64'd40);
    check("rf_commitK", bus.mat_cfg_sync_xmsize_csr >> 16, 64'd40);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      if (!model_full() && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 7))
          0: meta = 4'($urandom_range(0, 15));
          1, 2: meta = OP_ALL;
          3: meta = OP_M;
          4: meta = OP_N;
          default: meta = OP_K;
        endcase
        issue(meta, {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)));
      end
      if (exp_q.size() > 0 && $urandom_range(0, 2) == 0) retire_head();
      if ($urandom_range(0, 15) == 0) bus.rtu_yy_xx_flush = 1'b1;
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
